// File: rtl/circuit4_pkg.sv
// Shared types and constants for the circuit4 capture path.
// No logic; pure declarations.
// Used by the collector control and datapath.
package circuit4_pkg;

  // Samples per frame when the collector is instantiated without overrides.
  localparam int DEPTH_DEF = 8;

  // Width of the completed-frame counter; wraps 255 -> 0.
  localparam int FRAME_CNT_W = 8;

  // COLLECT: accepting samples. FULL: completed frame presented downstream.
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

endpackage

// File: rtl/circuit4_collector_ctrl.sv
// Frame FSM and sample index for the circuit4 collector; emits per-bit write enables and strobes.
// Latency: out_valid rises the cycle after the DEPTH-th accepted sample.
// Backpressure: in_ready drops while a frame is held in FULL or while clear is asserted.
module circuit4_collector_ctrl
  import circuit4_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             accept,
  output logic             handoff,
  output logic             flush,
  output logic [DEPTH-1:0] wr_en
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  assign in_ready  = (state_q == COLLECT) && !clear;
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid && in_ready;
  // clear outranks the handoff: an aborted frame is never counted.
  assign handoff   = out_valid && out_ready && !clear;
  assign flush     = clear;

  // State and index registers; reset lands in COLLECT with index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: clear first, then accept (COLLECT only), then handoff (FULL only).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clear) begin
      state_d = COLLECT;
      idx_d   = '0;
    end else if (accept) begin
      if (idx_q == LAST_IDX) begin
        state_d = FULL;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + CNT_W'(1);
      end
    end else if (handoff) begin
      state_d = COLLECT;
    end
  end

  // One-hot write enable selecting the bit slot for the accepted sample.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en[i] = accept && (idx_q == CNT_W'(i));
    end
  end

endmodule

// File: rtl/circuit4_collector.sv
// Packs DEPTH s0/cout samples into sum/carry words with a running carry popcount.
// Latency: frame presented one cycle after its last sample; handoff takes one FULL cycle.
// Backpressure: frame held stable while out_ready is low; no samples accepted meanwhile.
module circuit4_collector
  import circuit4_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   s0,
  input  logic                   cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DEPTH-1:0]       sum_word,
  output logic [DEPTH-1:0]       carry_word,
  output logic [CNT_W-1:0]       carry_count,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  logic             accept;
  logic             handoff;
  logic             flush;
  logic [DEPTH-1:0] wr_en;

  logic [DEPTH-1:0]       sum_q, sum_d;
  logic [DEPTH-1:0]       carry_q, carry_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;

  circuit4_collector_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .accept    (accept),
    .handoff   (handoff),
    .flush     (flush),
    .wr_en     (wr_en)
  );

  // Frame datapath registers; everything returns to zero on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      carry_q <= '0;
      count_q <= '0;
      frame_q <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      frame_q <= frame_d;
    end
  end

  // Datapath next-state: flush wipes the frame, handoff wipes and counts, accept writes one slot.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;
    frame_d = frame_q;
    if (flush) begin
      sum_d   = '0;
      carry_d = '0;
      count_d = '0;
    end else if (handoff) begin
      sum_d   = '0;
      carry_d = '0;
      count_d = '0;
      frame_d = frame_q + FRAME_CNT_W'(1);
    end else if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          sum_d[i]   = s0;
          carry_d[i] = cout;
        end
      end
      // Slots are written once per frame, so the increment tracks popcount(carry_word).
      count_d = count_q + CNT_W'(cout);
    end
  end

  assign sum_word    = sum_q;
  assign carry_word  = carry_q;
  assign carry_count = count_q;
  assign frame_cnt   = frame_q;

endmodule
